// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU memory port bundle between requester and mem_responder
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with WAIT wait states
// Optional out-of-range err flag enabled by defining MEM_RESP_ERR_EN.
module mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 1
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

  state_t            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             in_range;
  logic [IDX_W-1:0] ram_idx;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign ram_idx  = addr_q[IDX_W-1:0];

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (WAIT > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          // Out-of-range reads return zero rather than an aliased word
          if (!we_q) rdata_q <= in_range ? mem[ram_idx] : '0;
`ifdef MEM_RESP_ERR_EN
          err_q   <= !in_range;
`endif
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
`ifdef MEM_RESP_ERR_EN
          err_q   <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM is not reset; a reset before ACCESS leaves state_q out of ACCESS so no write lands
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q && in_range) mem[ram_idx] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at WAIT=0, 2 and 3
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst3_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

`ifdef MEM_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[3][$];
  logic [15:0] last_rd[3];

  mem_responder_if #(.DATA_W(16), .ADDR_W(10)) if0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(10)) if1 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(10)) if2 ();

  mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .WAIT(0))
    dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT(2))
    dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT(3))
    dut2 (.clk(clk), .reset(rst3_n), .bus(if2));

  function automatic int wait_of(int idx);
    case (idx)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic ack_of(int idx);
    case (idx)
      0:       return if0.ack;
      1:       return if1.ack;
      default: return if2.ack;
    endcase
  endfunction

  function automatic logic busy_of(int idx);
    case (idx)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [15:0] rdata_of(int idx);
    case (idx)
      0:       return if0.rdata;
      1:       return if1.rdata;
      default: return if2.rdata;
    endcase
  endfunction

  function automatic logic err_of(int idx);
    case (idx)
      0:       return if0.err;
      1:       return if1.err;
      default: return if2.err;
    endcase
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drv(int idx, logic r, logic w, logic [9:0] a, logic [15:0] d);
    case (idx)
      0: begin if0.req = r; if0.we = w; if0.addr = a; if0.wdata = d; end
      1: begin if1.req = r; if1.we = w; if1.addr = a; if1.wdata = d; end
      default: begin if2.req = r; if2.we = w; if2.addr = a; if2.wdata = d; end
    endcase
  endtask

  task automatic push_exp(int idx, logic e_err, int ack_cyc);
    exp_t e;
    e.data    = last_rd[idx];
    e.err     = e_err;
    e.ack_cyc = ack_cyc;
    sb[idx].push_back(e);
  endtask

  task automatic mon(int idx, logic [15:0] rd, logic er);
    exp_t e;
    if (sb[idx].size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack dut%0d: got ack=1 expected none", idx);
    end else begin
      e = sb[idx].pop_front();
      chk("rdata", idx, 32'(rd), 32'(e.data));
      chk("err", idx, 32'(er), 32'(e.err));
      chk("ack_cycle", idx, cyc, e.ack_cyc);
    end
  endtask

  always @(negedge clk) if (if0.ack === 1'b1) mon(0, if0.rdata, if0.err);
  always @(negedge clk) if (if1.ack === 1'b1) mon(1, if1.rdata, if1.err);
  always @(negedge clk) if (if2.ack === 1'b1) mon(2, if2.rdata, if2.err);

  task automatic wait_idle(int idx);
    int n = 0;
    @(negedge clk);
    while (busy_of(idx) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One isolated transfer; inputs are scrambled after acceptance to prove latching
  task automatic xfer(int idx, logic w, logic [9:0] a, logic [15:0] d,
                      logic [15:0] exp_rd, logic exp_err);
    int acc;
    int n;
    wait_idle(idx);
    drv(idx, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!w) last_rd[idx] = exp_rd;
    push_exp(idx, exp_err, acc + wait_of(idx) + 1);
    @(negedge clk);
    drv(idx, 1'b0, ~w, ~a, ~d);
    n = 0;
    while (busy_of(idx) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", idx, n, wait_of(idx) + 2);
    chk("ack_seen", idx, sb[idx].size(), 0);
  endtask

  task automatic held_run();
    logic [15:0] vals[4];
    int acc;
    int n;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    wait_idle(1);
    drv(1, 1'b1, 1'b1, 10'd0, vals[0]);
    @(posedge clk);
    #1;
    acc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) last_rd[1] = vals[i / 2];
      push_exp(1, 1'b0, acc + 3 + i * 5);
      @(negedge clk);
      n = 0;
      while (!ack_of(1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("held_timeout", 1, n, 0);
      if (i < 7) drv(1, 1'b1, ((i + 1) % 2 == 0), 10'((i + 1) / 2), vals[(i + 1) / 2]);
      else       drv(1, 1'b0, 1'b0, 10'd0, 16'd0);
    end
    wait_idle(1);
    chk("held_drained", 1, sb[1].size(), 0);
  endtask

  task automatic reset_abort();
    wait_idle(2);
    drv(2, 1'b1, 1'b1, 10'd7, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    drv(2, 1'b0, 1'b0, 10'd0, 16'd0);
    chk("mid_busy", 2, 32'(busy_of(2)), 32'd1);
    rst3_n = 1'b0;
    #1;
    chk("rst_ack", 2, 32'(ack_of(2)), 32'd0);
    chk("rst_busy", 2, 32'(busy_of(2)), 32'd0);
    chk("rst_rdata", 2, 32'(rdata_of(2)), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    last_rd[2] = 16'h0000;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 2, 32'(busy_of(2)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      drv(i, 1'b0, 1'b0, 10'd0, 16'd0);
      last_rd[i] = 16'h0000;
    end
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("idle_ack", i, 32'(ack_of(i)), 32'd0);
        chk("idle_busy", i, 32'(busy_of(i)), 32'd0);
        chk("idle_rdata", i, 32'(rdata_of(i)), 32'd0);
        chk("idle_err", i, 32'(err_of(i)), 32'd0);
      end
    end

    xfer(0, 1'b1, 10'd5,   16'hBEEF, 16'h0000, 1'b0);
    xfer(0, 1'b0, 10'd5,   16'h0000, 16'hBEEF, 1'b0);
    xfer(0, 1'b1, 10'd88,  16'h0088, 16'h0000, 1'b0);
    xfer(0, 1'b1, 10'd600, 16'h1234, 16'h0000, ERR_EN);
    xfer(0, 1'b0, 10'd600, 16'h0000, 16'h0000, ERR_EN);
    xfer(0, 1'b0, 10'd88,  16'h0000, 16'h0088, 1'b0);
    xfer(0, 1'b1, 10'd511, 16'h7FFF, 16'h0000, 1'b0);
    xfer(0, 1'b0, 10'd511, 16'h0000, 16'h7FFF, 1'b0);
    xfer(0, 1'b0, 10'd512, 16'h0000, 16'h0000, ERR_EN);
    xfer(0, 1'b0, 10'd5,   16'h0000, 16'hBEEF, 1'b0);

    xfer(1, 1'b1, 10'd5, 16'h0F0F, 16'h0000, 1'b0);
    xfer(1, 1'b0, 10'd5, 16'h0000, 16'h0F0F, 1'b0);
    held_run();
    xfer(1, 1'b0, 10'd2, 16'h0000, 16'h3333, 1'b0);

    xfer(2, 1'b1, 10'd7, 16'h5555, 16'h0000, 1'b0);
    xfer(2, 1'b0, 10'd7, 16'h0000, 16'h5555, 1'b0);
    reset_abort();
    xfer(2, 1'b0, 10'd7, 16'h0000, 16'h5555, 1'b0);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("sb_empty", i, sb[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
